// File: rtl/rfa_wb_queue.sv
// rfa_wb_queue
//   Writeback queue sitting between one SIMD/SIMF functional unit and the
//   register file arbiter. Completed writebacks (dest addr, wavefront id,
//   exec mask, data) are buffered in a small circular FIFO. The head entry is
//   offered to the arbiter, and the arbiter's grant pops it. full/almost_full
//   back-pressure the functional unit.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   push_valid, push_*       writeback from the functional unit
//   full, almost_full        back-pressure, decoded from registered count
//   queue_entry_valid        head entry present (count != 0)
//   queue_entry_serviced     arbiter grant, pops the head entry
//   head_*                   head entry fields, forced to zero when empty
//   count                    occupancy 0..DEPTH
//   overflow_err             sticky: push attempted while full
//   underflow_err            sticky: grant received while empty
module rfa_wb_queue #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 10,
    parameter int WFID_W     = 6,
    parameter int MASK_W     = 64,
    parameter int DEPTH_LOG2 = 2,
    parameter int AFULL_LVL  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [ADDR_W-1:0]     push_dest_addr,
    input  logic [WFID_W-1:0]     push_wfid,
    input  logic [MASK_W-1:0]     push_exec_mask,
    input  logic [DATA_W-1:0]     push_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  queue_entry_valid,
    input  logic                  queue_entry_serviced,
    output logic [ADDR_W-1:0]     head_dest_addr,
    output logic [WFID_W-1:0]     head_wfid,
    output logic [MASK_W-1:0]     head_exec_mask,
    output logic [DATA_W-1:0]     head_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] dest_addr;
        logic [WFID_W-1:0] wfid;
        logic [MASK_W-1:0] exec_mask;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Entry storage carries no reset; occupancy is tracked by count_q alone.
    entry_t mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_err_q, overflow_err_d;
    logic                  underflow_err_q, underflow_err_d;

    logic   is_full;
    logic   is_empty;
    logic   push_acc;
    logic   pop;
    entry_t push_entry;
    entry_t head_entry;

    // Full is judged on the registered count only, so a push while full is
    // dropped even if the arbiter pops in the same cycle.
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign push_acc = push_valid && !is_full;
    assign pop      = queue_entry_serviced && !is_empty;

    assign push_entry = '{dest_addr: push_dest_addr, wfid: push_wfid,
                          exec_mask: push_exec_mask, data: push_data};

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;

        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop);

        if (push_valid && is_full)          overflow_err_d  = 1'b1;
        if (queue_entry_serviced && is_empty) underflow_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_entry;
    end

    // Head is a plain read of the storage, masked so stale contents never
    // leak out while the queue is empty.
    assign head_entry = is_empty ? '0 : mem_q[rd_ptr_q];

    assign head_dest_addr    = head_entry.dest_addr;
    assign head_wfid         = head_entry.wfid;
    assign head_exec_mask    = head_entry.exec_mask;
    assign head_data         = head_entry.data;
    assign full              = is_full;
    assign almost_full       = (count_q >= CNT_W'(AFULL_LVL));
    assign queue_entry_valid = !is_empty;
    assign count             = count_q;
    assign overflow_err      = overflow_err_q;
    assign underflow_err     = underflow_err_q;

endmodule
